// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_MUL = 2'b01
    } st_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Combinational load-use detector between the load in EX and the sources of the ID instruction.
module hazard_compare
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RW = pipeline_hazard_ctrl_pkg::REG_W
) (
    input  logic          memread,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic          uses_rs,
    input  logic          uses_rt,
    output logic          hazard
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = uses_rs && (rs == rd);
        rt_match = uses_rt && (rt == rd);
        hazard   = memread && (rd != RW'(ZERO_REG)) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with multiply occupancy FSM and stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned REG_W       = pipeline_hazard_ctrl_pkg::REG_W,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_memread,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic [REG_W-1:0] IFID_rs,
    input  logic [REG_W-1:0] IFID_rt,
    input  logic             IFID_uses_rs,
    input  logic             IFID_uses_rt,
    input  logic             ID_mul_start,
    input  logic             EX_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             IFID_we,
    output logic             IFID_flush,
    output logic             IDEX_we,
    output logic             IDEX_flush,
    output logic             EXMEM_we,
    output logic             EXMEM_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MUL_CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [MUL_CW-1:0] MUL_INIT = MUL_CW'(MUL_LATENCY - 2);

    st_e               st_q, st_d;
    logic [MUL_CW-1:0] mul_cnt_q, mul_cnt_d;
    logic              hazard;

    hazard_compare #(
        .RW(REG_W)
    ) u_hazard_compare (
        .memread(IDEX_memread),
        .rd     (IDEX_rd),
        .rs     (IFID_rs),
        .rt     (IFID_rt),
        .uses_rs(IFID_uses_rs),
        .uses_rt(IFID_uses_rt),
        .hazard (hazard)
    );

    always_comb begin
        st_d         = st_q;
        mul_cnt_d    = mul_cnt_q;
        pc_we        = 1'b1;
        IFID_we      = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_we      = 1'b1;
        IDEX_flush   = 1'b0;
        EXMEM_we     = 1'b1;
        EXMEM_bubble = 1'b0;

        case (st_q)
            ST_RUN: begin
                if (mem_busy) begin
                    {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b0000;
                end else if (EX_branch_taken) begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                end else if (hazard) begin
                    pc_we      = 1'b0;
                    IFID_we    = 1'b0;
                    IDEX_flush = 1'b1;
                end else if (ID_mul_start) begin
                    st_d      = ST_MUL;
                    mul_cnt_d = MUL_INIT;
                end
            end
            ST_MUL: begin
                if (mem_busy) begin
                    {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b0000;
                end else if (mul_cnt_q != '0) begin
                    {pc_we, IFID_we, IDEX_we} = 3'b000;
                    EXMEM_bubble = 1'b1;
                    mul_cnt_d    = mul_cnt_q - 1'b1;
                end else begin
                    // Final cycle: the branch slot is occupied by the multiply, so no squash here
                    st_d = ST_RUN;
                    if (hazard) begin
                        pc_we      = 1'b0;
                        IFID_we    = 1'b0;
                        IDEX_flush = 1'b1;
                    end else if (ID_mul_start) begin
                        st_d      = ST_MUL;
                        mul_cnt_d = MUL_INIT;
                    end
                end
            end
            default: begin
                st_d      = ST_RUN;
                mul_cnt_d = '0;
            end
        endcase

        // Hold the whole pipe while reset is asserted
        if (!rst) begin
            {pc_we, IFID_we, IFID_flush, IDEX_we} = 4'b0000;
            {IDEX_flush, EXMEM_we, EXMEM_bubble}  = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= ST_RUN;
            mul_cnt_q    <= '0;
            stall_cycles <= '0;
        end else begin
            st_q      <= st_d;
            mul_cnt_q <= mul_cnt_d;
            if (!pc_we && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues expectations, negedge monitor checks.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    // {pc_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush, EXMEM_we, EXMEM_bubble}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] ZERO = 7'b0000000;
    localparam logic [6:0] BR   = 7'b1111110;
    localparam logic [6:0] LU   = 7'b0001110;
    localparam logic [6:0] MF   = 7'b0000011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             IDEX_memread = 1'b0;
    logic [REG_W-1:0] IDEX_rd = '0;
    logic [REG_W-1:0] IFID_rs = '0;
    logic [REG_W-1:0] IFID_rt = '0;
    logic             IFID_uses_rs = 1'b0;
    logic             IFID_uses_rt = 1'b0;
    logic             ID_mul_start = 1'b0;
    logic             EX_branch_taken = 1'b0;
    logic             mem_busy = 1'b0;
    logic             pc_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush, EXMEM_we, EXMEM_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic [6:0]       outs;

    typedef struct {
        string            name;
        logic [6:0]       outs;
        logic [CNT_W-1:0] sc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl #(
        .MUL_LATENCY(4),
        .REG_W      (REG_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IDEX_memread   (IDEX_memread),
        .IDEX_rd        (IDEX_rd),
        .IFID_rs        (IFID_rs),
        .IFID_rt        (IFID_rt),
        .IFID_uses_rs   (IFID_uses_rs),
        .IFID_uses_rt   (IFID_uses_rt),
        .ID_mul_start   (ID_mul_start),
        .EX_branch_taken(EX_branch_taken),
        .mem_busy       (mem_busy),
        .pc_we          (pc_we),
        .IFID_we        (IFID_we),
        .IFID_flush     (IFID_flush),
        .IDEX_we        (IDEX_we),
        .IDEX_flush     (IDEX_flush),
        .EXMEM_we       (EXMEM_we),
        .EXMEM_bubble   (EXMEM_bubble),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush, EXMEM_we, EXMEM_bubble};

    // One cycle of stimulus, applied just after the rising edge, plus its expected response
    task automatic cyc(input string nm, input logic r, input logic mr, input int rd, input int rs,
                       input int rt, input logic urs, input logic urt, input logic mul,
                       input logic br, input logic busy, input logic [6:0] eo, input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        IDEX_memread    = mr;
        IDEX_rd         = REG_W'(rd);
        IFID_rs         = REG_W'(rs);
        IFID_rt         = REG_W'(rt);
        IFID_uses_rs    = urs;
        IFID_uses_rt    = urt;
        ID_mul_start    = mul;
        EX_branch_taken = br;
        mem_busy        = busy;
        e.name = nm;
        e.outs = eo;
        e.sc   = CNT_W'(sc);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (outs !== e.outs) begin
                bad++;
                $display("FAIL %s outs: got %b want %b", e.name, outs, e.outs);
            end
            total++;
            if (stall_cycles !== e.sc) begin
                bad++;
                $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
            end
        end
    end

    initial begin
        //   name          rst mr rd rs rt urs urt mul br busy  exp   sc
        cyc("reset",       0,  0, 0, 0, 0, 0,  0,  0,  0, 0,    ZERO, 0);
        cyc("release",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 0);
        cyc("lu_rs",       1,  1, 5, 5, 0, 1,  0,  0,  0, 0,    LU,   0);
        cyc("after_lu",    1,  0, 0, 5, 0, 1,  0,  0,  0, 0,    NORM, 1);
        cyc("rd_zero",     1,  1, 0, 0, 0, 1,  0,  0,  0, 0,    NORM, 1);
        cyc("lu_rt",       1,  1, 7, 3, 7, 1,  1,  0,  0, 0,    LU,   1);
        cyc("rt_unused",   1,  1, 7, 0, 7, 0,  0,  0,  0, 0,    NORM, 2);
        cyc("br_and_lu",   1,  1, 5, 5, 0, 1,  0,  0,  1, 0,    BR,   2);
        cyc("busy_br",     1,  0, 0, 0, 0, 0,  0,  0,  1, 1,    ZERO, 2);
        cyc("mul_start",   1,  0, 0, 0, 0, 0,  0,  1,  0, 0,    NORM, 3);
        cyc("mul_f1",      1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   3);
        cyc("mul_f2",      1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   4);
        cyc("mul_fin_br",  1,  0, 0, 0, 0, 0,  0,  0,  1, 0,    NORM, 5);
        cyc("run_again",   1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 5);
        cyc("mul2_start",  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,    NORM, 5);
        cyc("mul2_f1",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   5);
        cyc("mul2_busy1",  1,  0, 0, 0, 0, 0,  0,  0,  0, 1,    ZERO, 6);
        cyc("mul2_busy2",  1,  0, 0, 0, 0, 0,  0,  0,  0, 1,    ZERO, 7);
        cyc("mul2_f2",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   8);
        cyc("mul2_fin_lu", 1,  1, 9, 9, 0, 1,  0,  0,  0, 0,    LU,   9);
        cyc("post_lu",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 10);
        cyc("mul3_start",  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,    NORM, 10);
        cyc("rst_in_mul",  0,  0, 0, 0, 0, 0,  0,  0,  0, 0,    ZERO, 0);
        cyc("rst_release", 1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 0);
        cyc("mul4_start",  1,  0, 0, 0, 0, 0,  0,  1,  0, 0,    NORM, 0);
        cyc("mul4_f1",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   0);
        cyc("mul4_f2",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   1);
        cyc("mul4_fin_mul",1,  0, 0, 0, 0, 0,  0,  1,  0, 0,    NORM, 2);
        cyc("mul5_f1",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   2);
        cyc("mul5_f2",     1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    MF,   3);
        cyc("mul5_fin",    1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 4);
        cyc("tail",        1,  0, 0, 0, 0, 0,  0,  0,  0, 0,    NORM, 4);

        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
